// File: rtl/pkg_display_7seg.sv
// Shared constants for the multiplexed 7-segment driver: hex glyphs in
// active-high {g,f,e,d,c,b,a} order, segment bit positions and a polarity helper.
package pkg_display_7seg;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Converts an active-high segment pattern to the pin polarity.
  function automatic logic [6:0] pol_seg(input logic [6:0] v, input logic act_bajo);
    logic [6:0] r;
    if (act_bajo) begin
      r = ~v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/deco_hex_7seg.sv
// Combinational hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module deco_hex_7seg
  import pkg_display_7seg::*;
(
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Seg
);

  // Full 0-F glyph table.
  always_comb begin
    o_Seg = SEG_OFF;
    case (i_Nibble)
      4'h0: o_Seg = SEG_0;
      4'h1: o_Seg = SEG_1;
      4'h2: o_Seg = SEG_2;
      4'h3: o_Seg = SEG_3;
      4'h4: o_Seg = SEG_4;
      4'h5: o_Seg = SEG_5;
      4'h6: o_Seg = SEG_6;
      4'h7: o_Seg = SEG_7;
      4'h8: o_Seg = SEG_8;
      4'h9: o_Seg = SEG_9;
      4'hA: o_Seg = SEG_A;
      4'hB: o_Seg = SEG_B;
      4'hC: o_Seg = SEG_C;
      4'hD: o_Seg = SEG_D;
      4'hE: o_Seg = SEG_E;
      4'hF: o_Seg = SEG_F;
      default: o_Seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/controlador_display_7seg_n.sv
// Multiplexed N-digit 7-segment driver: shadow-buffered data, blanking, leading-zero
// suppression and PWM brightness where sub-phase 0 of every slot is a dark dead time.
module controlador_display_7seg_n
  import pkg_display_7seg::*;
#(
  parameter int N_DIGITOS      = 4,
  parameter int PRESC          = 3125,
  parameter int BRILLO_BITS    = 4,
  parameter int ANODO_ACT_BAJO = 1,
  parameter int SEG_ACT_BAJO   = 1
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic [4*N_DIGITOS-1:0]   i_Datos,
  input  logic [N_DIGITOS-1:0]     i_Punto,
  input  logic [N_DIGITOS-1:0]     i_Blank,
  input  logic                     i_Carga,
  input  logic                     i_Supr_Ceros,
  input  logic [BRILLO_BITS-1:0]   i_Brillo,
  output logic [N_DIGITOS-1:0]     o_Anodo,
  output logic [6:0]               o_Segmentos,
  output logic                     o_Punto,
  output logic                     o_Fin_Barrido
);

  localparam int   PW     = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int   DW     = $clog2(N_DIGITOS);
  localparam logic INV_AN = (ANODO_ACT_BAJO != 0);
  localparam logic INV_SG = (SEG_ACT_BAJO != 0);

  localparam logic [N_DIGITOS-1:0] ANODO_OFF = INV_AN ? {N_DIGITOS{1'b1}} : {N_DIGITOS{1'b0}};
  localparam logic [6:0]           SEGS_OFF  = INV_SG ? 7'b1111111 : 7'b0000000;

  logic [4*N_DIGITOS-1:0] datos_q, datos_d;
  logic [N_DIGITOS-1:0]   punto_q, punto_d;
  logic [N_DIGITOS-1:0]   blank_q, blank_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [BRILLO_BITS-1:0] sub_q, sub_d;
  logic [DW-1:0]          dig_q, dig_d;
  logic [BRILLO_BITS-1:0] brillo_q, brillo_d;
  logic                   lit_q, lit_d;
  logic [N_DIGITOS-1:0]   anodo_q, anodo_d;
  logic [6:0]             seg_q, seg_d;
  logic                   pto_q, pto_d;
  logic                   fin_q, fin_d;

  logic                   presc_tc_s, sub_tc_s, dig_tc_s, frontera_s;
  logic [3:0]             nibble_s;
  logic [6:0]             glifo_s;
  logic [N_DIGITOS-1:0]   supr_vec_s;
  logic                   acc_s, blank_s, supr_s, pto_s;
  logic [N_DIGITOS-1:0]   anodo_act_s;
  int                     idx_s;

  deco_hex_7seg u_deco (
    .i_Nibble (nibble_s),
    .o_Seg    (glifo_s)
  );

  // Shadow load and scan counters.
  always_comb begin
    datos_d = datos_q;
    punto_d = punto_q;
    blank_d = blank_q;
    if (i_Carga) begin
      datos_d = i_Datos;
      punto_d = i_Punto;
      blank_d = i_Blank;
    end else begin
      datos_d = datos_q;
    end

    presc_tc_s = (presc_q == PW'(PRESC - 1));
    sub_tc_s   = (&sub_q);
    dig_tc_s   = (dig_q == DW'(N_DIGITOS - 1));
    frontera_s = (presc_q == '0) && (sub_q == '0);

    presc_d = presc_tc_s ? '0 : presc_q + PW'(1);
    sub_d   = sub_q;
    dig_d   = dig_q;
    if (presc_tc_s) begin
      sub_d = sub_q + BRILLO_BITS'(1);
      if (sub_tc_s) begin
        dig_d = dig_tc_s ? '0 : dig_q + DW'(1);
      end else begin
        dig_d = dig_q;
      end
    end else begin
      sub_d = sub_q;
    end
    fin_d = presc_tc_s && sub_tc_s && dig_tc_s;
  end

  // Per-slot content; the boundary sees freshly loaded shadow values (load-then-display).
  always_comb begin
    idx_s    = int'(dig_q);
    nibble_s = datos_d[4*idx_s +: 4];
    acc_s    = 1'b1;
    supr_vec_s = '0;
    for (int k = N_DIGITOS - 1; k >= 0; k--) begin
      acc_s         = acc_s & (datos_d[4*k +: 4] == 4'h0);
      supr_vec_s[k] = acc_s;
    end
    supr_vec_s[0] = 1'b0;

    blank_s = blank_d[idx_s];
    supr_s  = i_Supr_Ceros && supr_vec_s[idx_s];
    pto_s   = punto_d[idx_s] && !blank_s;

    brillo_d = brillo_q;
    lit_d    = lit_q;
    seg_d    = seg_q;
    pto_d    = pto_q;
    if (frontera_s) begin
      brillo_d = i_Brillo;
      lit_d    = !blank_s && (!supr_s || pto_s);
      seg_d    = pol_seg((blank_s || supr_s) ? SEG_OFF : glifo_s, INV_SG);
      pto_d    = INV_SG ? !pto_s : pto_s;
    end else begin
      brillo_d = brillo_q;
    end
  end

  // Anode PWM: sub-phase 0 is always dark so segments settle before lighting.
  always_comb begin
    anodo_act_s = '0;
    if (lit_q && (sub_q != '0) && (sub_q <= brillo_q)) begin
      anodo_act_s[idx_s] = 1'b1;
    end else begin
      anodo_act_s = '0;
    end
    anodo_d = INV_AN ? ~anodo_act_s : anodo_act_s;
  end

  // State and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      datos_q  <= '0;
      punto_q  <= '0;
      blank_q  <= '0;
      presc_q  <= '0;
      sub_q    <= '0;
      dig_q    <= '0;
      brillo_q <= '0;
      lit_q    <= 1'b0;
      anodo_q  <= ANODO_OFF;
      seg_q    <= SEGS_OFF;
      pto_q    <= INV_SG;
      fin_q    <= 1'b0;
    end else begin
      datos_q  <= datos_d;
      punto_q  <= punto_d;
      blank_q  <= blank_d;
      presc_q  <= presc_d;
      sub_q    <= sub_d;
      dig_q    <= dig_d;
      brillo_q <= brillo_d;
      lit_q    <= lit_d;
      anodo_q  <= anodo_d;
      seg_q    <= seg_d;
      pto_q    <= pto_d;
      fin_q    <= fin_d;
    end
  end

  assign o_Anodo       = anodo_q;
  assign o_Segmentos   = seg_q;
  assign o_Punto       = pto_q;
  assign o_Fin_Barrido = fin_q;

endmodule

// File: doc/controlador_display_7seg_n.md
Name: controlador_display_7seg_n

Overview:
- Parametrised multiplexed 7-segment display driver for N common-anode or common-cathode digits.
- Time-multiplexes hex digits onto one shared segment bus and adds the following:
  - double-buffered data load;
  - per-digit blanking and decimal point;
  - leading-zero suppression;
  - PWM brightness with a built-in anti-ghosting dead time.
- Sits between application logic (counters, FSM status) and the board display pins.

Parameters:
- N_DIGITOS, 4, number of digits scanned (2..8). Digit N_DIGITOS-1 is the most significant (leftmost).
- PRESC, 3125, i_Clk cycles per brightness sub-phase (>=1).
- BRILLO_BITS, 4, width of i_Brillo. Each digit slot = 2^BRILLO_BITS sub-phases = PRESC*2^BRILLO_BITS cycles.
- ANODO_ACT_BAJO, 1, 1 = o_Anodo active-low, 0 = active-high.
- SEG_ACT_BAJO, 1, 1 = o_Segmentos/o_Punto active-low, 0 = active-high.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Datos  in  4*N_DIGITOS  hex nibbles; digit k = i_Datos[4k+3:4k].
- i_Punto  in  N_DIGITOS  decimal point request per digit.
- i_Blank  in  N_DIGITOS  force digit k dark.
- i_Carga  in  1  single-cycle strobe: copy i_Datos/i_Punto/i_Blank into shadow registers.
- i_Supr_Ceros  in  1  enable leading-zero suppression.
- i_Brillo  in  BRILLO_BITS  brightness level, 0 = dark.
- o_Anodo  out  N_DIGITOS  one-hot digit enable (polarity per ANODO_ACT_BAJO).
- o_Segmentos  out  7  {g,f,e,d,c,b,a} (polarity per SEG_ACT_BAJO).
- o_Punto  out  1  decimal point segment.
- o_Fin_Barrido  out  1  one-cycle pulse when the scan wraps from digit N_DIGITOS-1 to digit 0.

Behaviour:
- Reset (i_Rst=0, asynchronous, effective immediately, including mid-scan):
  - shadow data, shadow point and shadow blank cleared to 0;
  - prescaler, sub-phase and digit index = 0;
  - all o_Anodo inactive, o_Segmentos and o_Punto inactive (all off), o_Fin_Barrido = 0.
- Shadow load: on a rising edge with i_Carga=1, shadow registers take the inputs. The new values are displayed from the next slot boundary, never mid-slot. Without i_Carga, input changes are ignored.
- Counters:
  - prescaler counts 0..PRESC-1;
  - at terminal count the sub-phase (BRILLO_BITS wide) increments;
  - on sub-phase wrap the digit index increments, wrapping N_DIGITOS-1 -> 0.
  - o_Fin_Barrido = 1 for exactly the cycle after the index wraps to 0.
- Slot boundary (sub-phase 0, prescaler 0), sampled in the same cycle:
  - i_Brillo latched into brillo_slot;
  - segment pattern and point for the current digit registered from the shadow.
- Anode drive: digit index active only when sub-phase != 0 and sub-phase <= brillo_slot.
  - Sub-phase 0 is always dark (dead time while segments change).
  - i_Brillo=0 -> never lit; max value -> (2^B-1)/2^B duty.
- Digit dark (anode inactive the entire slot) if any of:
  - shadow blank[k]=1;
  - suppression: i_Supr_Ceros=1 and k != 0 and nibbles k..N_DIGITOS-1 are all 0. Digit 0 always shows, so value 0 displays "0".
- Decimal point: o_Punto active when shadow punto[k]=1 and the digit is not blanked. Suppressed digits still show the point if requested.
- Decode: full hex 0-F. A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001 (active-high {g..a}); 0-9 standard.
- Latency: outputs registered; anode/segment changes appear 1 cycle after the counter event.
- i_Carga asserted on the same edge as a slot boundary: the boundary uses the new shadow values (load-then-display).

Decomposition:
- Package pkg_display_7seg: segment pattern constants for 0-F, segment bit-order constants, polarity helper function.
- One sub-module deco_hex_7seg: combinational 4-bit to 7-segment decoder, active-high; polarity applied in the top.

Test Plan (bench: PRESC=2, BRILLO_BITS=2, N_DIGITOS=4):
- Reset, then release with i_Brillo=3 -> exactly one anode active per 8-cycle slot, scan 0,1,2,3,0. o_Fin_Barrido pulses once per 32 cycles. Anode dark for the first 2 cycles of each slot.
- Load i_Datos=16'h12AF, i_Carga pulse -> segments per slot: F=1110001, A=1110111, 2=1011011, 1=0000110 (inverted at the pins for active-low).
- i_Supr_Ceros=1, load 16'h0005 -> digits 3,2,1 dark, digit 0 shows 5. Load 16'h0000 -> only digit 0 shows 0.
- i_Brillo=1 -> anode lit 2 of 8 cycles per slot. i_Brillo=0 -> no anode ever active. Change i_Brillo mid-slot -> duty changes only at the next slot.
- i_Blank=4'b0100, i_Punto=4'b0101 -> digit 2 fully dark including point; digit 0 point active.
- Assert i_Rst low mid-slot -> all outputs inactive in the same cycle, shadow cleared. After release, the scan restarts at digit 0, sub-phase 0.
